// File: rtl/mem_if_pkg.sv
// mem_if_pkg -- shared definitions for the multi-port memory interface.
//   * Controller FSM state enum.
//   * Default parameter values (channel count, address/data widths, timeout).
//   * Helper that sizes a channel-index register.
package mem_if_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_if_state_t;

  // Width needed to hold a channel index; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_mem_if_rr_arbiter.sv
// rr_arbiter -- combinational round-robin arbiter.
// Grants the lowest-index requesting channel at or above 'pointer', wrapping
// modulo NUM_CH. The grant is one-hot, or all zero when nothing is requesting.
// Ports:
//   req     [NUM_CH-1:0]  per-channel request
//   pointer [PTR_W-1:0]   channel with the highest priority this round
//   grant   [NUM_CH-1:0]  one-hot grant
module rr_arbiter
  import mem_if_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int PTR_W = ptr_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  pointer,
  output logic [NUM_CH-1:0] grant
);

  int   idx;
  logic found;

  // Walk the channels starting at the pointer; the first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(pointer) + i) % NUM_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_if.sv
// multi_port_mem_if -- shares one single-port memory among NUM_CH hosts.
// A round-robin arbiter picks a requesting channel in IDLE. Its command is
// latched and driven to memory during ACCESS until mem_ack. The completion is
// then reported to that channel with a one-cycle ready pulse in DONE.
// Optional feature: define MEM_IF_TIMEOUT_EN to abort an ACCESS that sees no
// mem_ack within TIMEOUT_CYC cycles. The abort reports err with ready and
// returns rdata=0. Without the macro, ACCESS waits forever and err is
// constant 0.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req, wr_en [NUM_CH]         per-channel request level and write/read select
//   addr  [NUM_CH*ADDR_W]       packed per-channel address
//   wdata [NUM_CH*DATA_W]       packed per-channel write data
//   rdata [DATA_W]              read data of the completing transaction
//   ready [NUM_CH]              one-hot completion pulse
//   err   [NUM_CH]              timeout flag, qualified by ready
//   mem_cs, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack  memory port
module multi_port_mem_if
  import mem_if_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        ready,
  output logic [NUM_CH-1:0]        err,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int PTR_W = ptr_width(NUM_CH);

  mem_if_state_t     state_q, state_d;
  logic [PTR_W-1:0]  pointer_q;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] grant_q;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  grant_idx_q;
  logic              start;
  logic              tmo_expire;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (req),
    .pointer (pointer_q),
    .grant   (grant)
  );

  // Convert the one-hot grant to an index for selecting the packed buses.
  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) grant_idx = PTR_W'(k);
    end
  end

`ifdef MEM_IF_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [NUM_CH-1:0] err_q;

  // The counter holds the number of ACCESS cycles already spent. The last
  // allowed cycle is the one where it reads TIMEOUT_CYC-1.
  assign tmo_expire = (state_q == ACCESS) && (tmo_cnt_q == TMO_LAST);
  assign err        = err_q;

  // Timeout counter and error flag. mem_ack is tested first, so an ack on the
  // final cycle still completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE:    tmo_cnt_q <= '0;
        ACCESS: begin
          if (!mem_ack) begin
            if (tmo_expire) err_q     <= grant_q;
            else            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        DONE:    err_q <= '0;
        default: ;
      endcase
    end
  end
`else
  localparam int UNUSED_TMO = TIMEOUT_CYC;

  assign tmo_expire = 1'b0;
  assign err        = '0;
`endif

  assign start = (state_q == IDLE) && (|req);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. req is looked at only in IDLE, and mem_ack only in ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (mem_ack || tmo_expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. The memory-port registers also serve as the latched command.
  // They are loaded at the grant edge and stay stable for the whole ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer_q   <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      ready       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            grant_q     <= grant;
            grant_idx_q <= grant_idx;
            mem_cs      <= 1'b1;
            mem_we      <= wr_en[grant_idx];
            mem_addr    <= addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            mem_wdata   <= wdata[int'(grant_idx)*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_cs <= 1'b0;
            ready  <= grant_q;
            if (!mem_we) rdata <= mem_rdata;
          end else if (tmo_expire) begin
            mem_cs <= 1'b0;
            ready  <= grant_q;
            rdata  <= '0;
          end
        end
        DONE: begin
          ready     <= '0;
          pointer_q <= (int'(grant_idx_q) == NUM_CH - 1) ? '0 : grant_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_port_mem_if.sv
// tb_multi_port_mem_if -- scoreboard bench for multi_port_mem_if.
// A transaction-level round-robin model predicts the order in which requests
// are served and what each one returns. Each prediction is queued when the
// stimulus is issued. A monitor pops the queue on every ready pulse and
// compares. A behavioural memory answers mem_cs with a random ack delay.
module tb_multi_port_mem_if;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        wr_en;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]        rdata;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH-1:0]        err;
  logic                     mem_cs;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_ack;

  always #5 clk = ~clk;

  multi_port_mem_if #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    int                ch;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] env_mem [logic [ADDR_W-1:0]];
  int                m_ptr;
  logic [DATA_W-1:0] m_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit                stall;
  int                resp_delay;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [NUM_CH-1:0] prev_ready;
  exp_t              mon_e;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Round-robin rule: first pending channel at or after ptr, wrapping.
  function automatic int rrPick(input logic [NUM_CH-1:0] pend, input int ptr);
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic void modelServe(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                                     input logic [DATA_W-1:0] d, input logic tmo);
    exp_t e;
    if (tmo) m_rdata = '0;
    else if (we) ref_mem[a] = d;
    else m_rdata = ref_mem.exists(a) ? ref_mem[a] : '0;
    e.ch = ch; e.err = tmo; e.rdata = m_rdata; e.we = we; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
    m_ptr = (ch + 1) % NUM_CH;
  endfunction

  // Behavioural memory: random 0..3 cycle ack delay, no ack while stalled.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; resp_delay = -1;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0; resp_delay = -1;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_cs && !stall) begin
        if (resp_delay < 0) resp_delay = $urandom_range(0, 3);
        if (resp_delay == 0) begin
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
          if (mem_we) begin
            env_mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
          end
          mem_ack = 1'b1;
          resp_delay = -1;
        end else begin
          resp_delay--;
        end
      end
    end
  end

  // Monitor: pops one prediction per ready pulse and compares.
  initial begin
    prev_ready = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ready != '0) begin
          checkOutput("ready_pulse", 64'(prev_ready), 64'd0);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_ready", 64'(ready), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("ready_ch", 64'(ready), 64'(1 << mon_e.ch));
            checkOutput("err", 64'(err), mon_e.err ? 64'(1 << mon_e.ch) : 64'd0);
            checkOutput("rdata", 64'(rdata), 64'(mon_e.rdata));
            if (!mon_e.err) begin
              checkOutput("mem_we", 64'(cap_we), 64'(mon_e.we));
              checkOutput("mem_addr", 64'(cap_addr), 64'(mon_e.addr));
              if (mon_e.we) checkOutput("mem_wdata", 64'(cap_wdata), 64'(mon_e.wdata));
            end
          end
        end else if (err != '0) begin
          checkOutput("err_unqualified", 64'(err), 64'd0);
        end
      end
      prev_ready = ready;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_cs"}, 64'(mem_cs), 64'd0);
    checkOutput({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
    checkOutput({tag, "_ready"}, 64'(ready), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic waitMemCs(input string name);
    for (int c = 0; c < 20 && !mem_cs; c++) @(negedge clk);
    if (!mem_cs) checkOutput(name, 64'(mem_cs), 64'd1);
  endtask

  // Issue a batch of simultaneous requests. Each host drops req in its
  // ready cycle.
  task automatic applyStimulus(input logic [NUM_CH-1:0] chs, input logic [NUM_CH-1:0] we_v,
                               input logic [NUM_CH*ADDR_W-1:0] a_v,
                               input logic [NUM_CH*DATA_W-1:0] d_v);
    logic [NUM_CH-1:0] pend;
    int c;
    pend = chs;
    while (pend != '0) begin
      c = rrPick(pend, m_ptr);
      modelServe(c, we_v[c], a_v[c*ADDR_W +: ADDR_W], d_v[c*DATA_W +: DATA_W], 1'b0);
      pend[c] = 1'b0;
    end
    @(negedge clk);
    wr_en = we_v; addr = a_v; wdata = d_v; req = chs;
    for (int cyc = 0; cyc < 400 && req != '0; cyc++) begin
      @(negedge clk);
      req = req & ~ready;
    end
    if (req != '0) begin
      checkOutput("stim_timeout", 64'(req), 64'd0);
      req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input int ch, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [NUM_CH-1:0]        chs  = '0;
    logic [NUM_CH-1:0]        we_v = '0;
    logic [NUM_CH*ADDR_W-1:0] a_v  = '0;
    logic [NUM_CH*DATA_W-1:0] d_v  = '0;
    chs[ch] = 1'b1; we_v[ch] = we;
    a_v[ch*ADDR_W +: ADDR_W] = a;
    d_v[ch*DATA_W +: DATA_W] = d;
    applyStimulus(chs, we_v, a_v, d_v);
  endtask

  initial begin
    logic [NUM_CH-1:0]        chs, we_v;
    logic [NUM_CH*ADDR_W-1:0] a_v;
    logic [NUM_CH*DATA_W-1:0] d_v;
    int n;
    int cnt;

    rst_n = 1'b0; req = '0; wr_en = '0; addr = '0; wdata = '0; stall = 1'b0;
    m_ptr = 0; m_rdata = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single write and readback");
    single(0, 1'b1, 16'h00A0, 32'hDEADBEEF);
    single(0, 1'b0, 16'h00A0, 32'h0);

    $display("[TB] four-way contention");
    chs = '1; we_v = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      a_v[k*ADDR_W +: ADDR_W] = 16'h0100 + 16'(k);
      d_v[k*DATA_W +: DATA_W] = 32'hA5A50000 + 32'(k);
    end
    applyStimulus(chs, we_v, a_v, d_v);
    we_v = '0;
    applyStimulus(chs, we_v, a_v, d_v);

    $display("[TB] fairness between ch1 and ch3");
    for (int i = 0; i < 4; i++) begin
      n = rrPick(4'b1010, m_ptr);
      modelServe(n, 1'b0, 16'h0100 + 16'(n), 32'h0, 1'b0);
    end
    @(negedge clk);
    wr_en = '0; addr = a_v; req = 4'b1010;
    n = 0;
    for (int cyc = 0; cyc < 200 && req != '0; cyc++) begin
      @(negedge clk);
      if (ready != '0) n++;
      if (n == 4) req = '0;
    end
    if (req != '0) begin
      checkOutput("fair_timeout", 64'(req), 64'd0);
      req = '0;
    end
    repeat (2) @(negedge clk);

    $display("[TB] randomized batches");
    for (int b = 0; b < 30; b++) begin
      chs = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int k = 0; k < NUM_CH; k++) begin
        we_v[k] = 1'($urandom_range(0, 1));
        a_v[k*ADDR_W +: ADDR_W] = 16'h0200 + 16'($urandom_range(0, 7));
        d_v[k*DATA_W +: DATA_W] = $urandom;
      end
      applyStimulus(chs, we_v, a_v, d_v);
    end
    waitDrain("random_drain", 20);

    $display("[TB] req dropped during ACCESS");
    stall = 1'b1;
    modelServe(0, 1'b1, 16'h0300, 32'h12345678, 1'b0);
    @(negedge clk);
    wr_en = 4'b0001; addr = '0; addr[ADDR_W-1:0] = 16'h0300;
    wdata[DATA_W-1:0] = 32'h12345678; req = 4'b0001;
    waitMemCs("drop_cs");
    repeat (2) @(negedge clk);
    req = '0; stall = 1'b0;
    waitDrain("drop_complete", 50);
    single(0, 1'b0, 16'h0300, 32'h0);

`ifdef MEM_IF_TIMEOUT_EN
    $display("[TB] access timeout");
    stall = 1'b1;
    modelServe(2, 1'b0, 16'h0102, 32'h0, 1'b1);
    @(negedge clk);
    wr_en = '0; addr[2*ADDR_W +: ADDR_W] = 16'h0102; req = 4'b0100;
    waitMemCs("tmo_cs");
    cnt = 0;
    while (mem_cs && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    req = '0;
    checkOutput("tmo_cycles", 64'(cnt), 64'(TIMEOUT_CYC));
    stall = 1'b0;
    waitDrain("tmo_drain", 10);
`endif

    $display("[TB] reset during ACCESS");
    single(2, 1'b1, 16'h0104, 32'hCAFEF00D);
    stall = 1'b1;
    @(negedge clk);
    wr_en = '0; addr[1*ADDR_W +: ADDR_W] = 16'h0100; req = 4'b0010;
    waitMemCs("rst_cs");
`ifdef MEM_IF_TIMEOUT_EN
    repeat (5) @(negedge clk);
`else
    repeat (40) @(negedge clk);
`endif
    checkOutput("cs_held", 64'(mem_cs), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    exp_q.delete();
    m_ptr = 0; m_rdata = '0; req = '0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chs = 4'b1001; we_v = 4'b1001;
    a_v[0 +: ADDR_W] = 16'h0400; a_v[3*ADDR_W +: ADDR_W] = 16'h0403;
    d_v[0 +: DATA_W] = 32'h0BADBEEF; d_v[3*DATA_W +: DATA_W] = 32'h600DF00D;
    applyStimulus(chs, we_v, a_v, d_v);
    single(3, 1'b0, 16'h0403, 32'h0);

    waitDrain("final_drain", 20);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
